// File: rtl/prbs_checker_if.sv
// Received PRBS word stream: one word per cycle when in_valid is high.
interface prbs_checker_if #(
   parameter int unsigned DATA = 3
);
   logic            in_valid;
   logic [DATA-1:0] in_data;

   modport master (output in_valid, output in_data);
   modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for LOCK_CNT consecutive predicted words, then
// free-runs a reference LFSR and counts mismatches until LOSS_CNT consecutive errors.
module prbs_checker #(
   parameter int unsigned DATA     = 3,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3,
   parameter int unsigned ERR_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   prbs_checker_if.slave      in_if,
   input  logic               err_clr,
   output logic               locked,
   output logic               err_pulse,
   output logic [ERR_W-1:0]   err_cnt
);

   if (DATA < 3 || DATA > 16) begin : g_bad_data
      $error("prbs_checker: DATA must be in 3..16");
      $fatal(1, "prbs_checker: illegal DATA");
   end
   if (LOCK_CNT < 1 || LOSS_CNT < 1) begin : g_bad_cnt
      $error("prbs_checker: LOCK_CNT and LOSS_CNT must be >= 1");
      $fatal(1, "prbs_checker: illegal LOCK_CNT/LOSS_CNT");
   end

   localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
   localparam int unsigned LossW  = $clog2(LOSS_CNT + 1);

   typedef enum logic [0:0] {StHunt, StLock} state_e;

   state_e              state_q, state_d;
   logic [DATA-1:0]     ref_q, ref_d;
   logic                have_prev_q, have_prev_d;
   logic [MatchW-1:0]   match_cnt_q, match_cnt_d;
   logic [LossW-1:0]    loss_cnt_q, loss_cnt_d;
   logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
   logic                err_pulse_q, err_pulse_d;

   // Shift left one place, feedback into bit 0; taps match the generator.
   function automatic logic [DATA-1:0] predict(input logic [DATA-1:0] w);
      logic [15:0] x;
      logic        fb;
      x = 16'(w);
      case (DATA)
         3:       fb = x[2] ^ x[1];
         4:       fb = x[3] ^ x[2];
         5:       fb = x[4] ^ x[2];
         6:       fb = x[5] ^ x[4];
         7:       fb = x[6] ^ x[5];
         8:       fb = x[7] ^ x[5] ^ x[4] ^ x[3];
         9:       fb = x[8] ^ x[4];
         10:      fb = x[9] ^ x[6];
         11:      fb = x[10] ^ x[8];
         12:      fb = x[11] ^ x[5] ^ x[3] ^ x[0];
         13:      fb = x[12] ^ x[3] ^ x[2] ^ x[0];
         14:      fb = x[13] ^ x[4] ^ x[2] ^ x[0];
         15:      fb = x[14] ^ x[13];
         16:      fb = x[15] ^ x[14] ^ x[12] ^ x[3];
         default: fb = 1'b0;
      endcase
      return {w[DATA-2:0], fb};
   endfunction

   logic [DATA-1:0]   pred;
   logic              hit;
   logic              hunt_match;
   logic [MatchW-1:0] match_inc;
   logic [LossW-1:0]  loss_inc;
   logic              lock_reached;
   logic              loss_reached;

   always_comb begin
      pred         = predict(ref_q);
      hit          = (in_if.in_data == pred);
      // All-zero is the LFSR lock-up word and must never help acquire lock.
      hunt_match   = have_prev_q && hit && (in_if.in_data != '0);
      match_inc    = match_cnt_q + MatchW'(1);
      loss_inc     = loss_cnt_q + LossW'(1);
      lock_reached = hunt_match && (match_inc == MatchW'(LOCK_CNT));
      loss_reached = !hit && (loss_inc == LossW'(LOSS_CNT));
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StHunt;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StHunt: if (in_if.in_valid && lock_reached) state_d = StLock;
         StLock: if (in_if.in_valid && loss_reached) state_d = StHunt;
         default: state_d = StHunt;
      endcase
   end

   // Datapath next-state
   always_comb begin
      ref_d       = ref_q;
      have_prev_d = have_prev_q;
      match_cnt_d = match_cnt_q;
      loss_cnt_d  = loss_cnt_q;
      err_pulse_d = 1'b0;
      err_cnt_d   = err_clr ? '0 : err_cnt_q;
      if (in_if.in_valid) begin
         unique case (state_q)
            StHunt: begin
               ref_d       = in_if.in_data;
               have_prev_d = 1'b1;
               if (lock_reached) begin
                  match_cnt_d = '0;
                  loss_cnt_d  = '0;
               end else if (hunt_match) begin
                  match_cnt_d = match_inc;
               end else begin
                  match_cnt_d = '0;
               end
            end
            StLock: begin
               // Reference free-runs so corrupted words cannot derail it.
               ref_d = pred;
               if (!hit) begin
                  err_pulse_d = 1'b1;
                  if (err_cnt_d != '1) err_cnt_d = err_cnt_d + ERR_W'(1);
                  if (loss_reached) begin
                     loss_cnt_d  = '0;
                     have_prev_d = 1'b0;
                     match_cnt_d = '0;
                  end else begin
                     loss_cnt_d = loss_inc;
                  end
               end else begin
                  loss_cnt_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ref_q       <= '0;
         have_prev_q <= 1'b0;
         match_cnt_q <= '0;
         loss_cnt_q  <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         ref_q       <= ref_d;
         have_prev_q <= have_prev_d;
         match_cnt_q <= match_cnt_d;
         loss_cnt_q  <= loss_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   // Outputs
   always_comb begin
      locked    = (state_q == StLock);
      err_pulse = err_pulse_q;
      err_cnt   = err_cnt_q;
   end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker with DATA=4, LOCK_CNT=4, LOSS_CNT=3, ERR_W=2.
module tb_prbs_checker;

   localparam int unsigned DATA     = 4;
   localparam int unsigned LOCK_CNT = 4;
   localparam int unsigned LOSS_CNT = 3;
   localparam int unsigned ERR_W    = 2;
   localparam int unsigned CNT_MAX  = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             err_clr;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_cnt;

   prbs_checker_if #(.DATA(DATA)) in_if ();

   prbs_checker #(
      .DATA     (DATA),
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT),
      .ERR_W    (ERR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_if     (in_if),
      .err_clr   (err_clr),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        locked;
      logic        pulse;
      int unsigned cnt;
   } exp_t;

   exp_t sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model state
   logic            m_locked;
   logic            m_pulse;
   int unsigned     m_cnt;
   logic [DATA-1:0] m_ref;
   logic            m_have;
   int unsigned     m_match;
   int unsigned     m_loss;

   logic [DATA-1:0] seq;   // next correct word of the generator stream

   function automatic logic [DATA-1:0] pred(input logic [DATA-1:0] w);
      return {w[2:0], w[3] ^ w[2]};
   endfunction

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update(input logic rst, input logic v, input logic [DATA-1:0] d,
                               input logic clr);
      logic [DATA-1:0] p;
      if (rst) begin
         m_locked = 1'b0; m_pulse = 1'b0; m_cnt = 0; m_ref = '0;
         m_have = 1'b0; m_match = 0; m_loss = 0;
         return;
      end
      m_pulse = 1'b0;
      if (clr) m_cnt = 0;
      if (!v) return;
      p = pred(m_ref);
      if (!m_locked) begin
         if (m_have && d == p && d != '0) begin
            m_match++;
            if (m_match == LOCK_CNT) begin
               m_locked = 1'b1; m_match = 0; m_loss = 0;
            end
         end else begin
            m_match = 0;
         end
         m_ref  = d;
         m_have = 1'b1;
      end else begin
         m_ref = p;
         if (d != p) begin
            m_pulse = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
            m_loss++;
            if (m_loss == LOSS_CNT) begin
               m_locked = 1'b0; m_have = 1'b0; m_match = 0; m_loss = 0;
            end
         end else begin
            m_loss = 0;
         end
      end
   endtask

   task automatic step(input logic rst, input logic v, input logic [DATA-1:0] d,
                       input logic clr);
      exp_t e;
      reset          = rst;
      in_if.in_valid = v;
      in_if.in_data  = d;
      err_clr        = clr;
      model_update(rst, v, d, clr);
      e.locked = m_locked;
      e.pulse  = m_pulse;
      e.cnt    = m_cnt;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("locked", locked, e.locked);
      check("err_pulse", err_pulse, e.pulse);
      check("err_cnt", err_cnt, e.cnt);
   endtask

   task automatic good(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, seq, 1'b0);
         seq = pred(seq);
      end
   endtask

   task automatic bad(input logic [DATA-1:0] mask);
      step(1'b0, 1'b1, seq ^ mask, 1'b0);
      seq = pred(seq);
   endtask

   initial begin
      seq = 4'b0001;
      step(1'b1, 1'b0, '0, 1'b0);
      check("reset_locked", locked, 0);
      check("reset_err_cnt", err_cnt, 0);

      // Acquire: 0001,0010,0100,1001 leave locked low, 0011 locks
      good(4);
      check("hunt_not_locked", locked, 0);
      good(1);
      check("lock_after_5", locked, 1);
      check("lock_err_cnt", err_cnt, 0);

      // 0110 good, 1100 instead of 1101, then 1010 good
      good(1);
      bad(4'b0001);
      check("single_pulse", err_pulse, 1);
      check("single_cnt", err_cnt, 1);
      good(1);
      check("ref_kept", err_pulse, 0);
      check("lock_held", locked, 1);

      // Clear, then three consecutive errors drop lock
      step(1'b0, 1'b1, seq, 1'b1);
      seq = pred(seq);
      check("clr_cnt", err_cnt, 0);
      bad(4'b0100);
      bad(4'b1000);
      check("loss_2_locked", locked, 1);
      bad(4'b0011);
      check("loss_cnt3", err_cnt, 3);
      check("loss_unlock", locked, 0);
      good(4);
      check("relock_pending", locked, 0);
      good(1);
      check("relock", locked, 1);

      // All-zero stream never locks
      step(1'b1, 1'b1, seq, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, 1'b0);
      check("zero_unlocked", locked, 0);
      check("zero_cnt", err_cnt, 0);

      // Gapped valid keeps lock, then reset mid-stream
      seq = 4'b0001;
      good(5);
      for (int i = 0; i < 10; i++) begin
         good(1);
         step(1'b0, 1'b0, 4'($urandom), 1'b0);
      end
      check("gap_locked", locked, 1);
      check("gap_cnt", err_cnt, 0);
      step(1'b1, 1'b1, seq, 1'b0);
      check("midrst_locked", locked, 0);
      check("midrst_cnt", err_cnt, 0);

      // Saturation at 3 with errors interleaved so lock holds
      seq = 4'b0001;
      good(5);
      for (int i = 0; i < 5; i++) begin
         bad(4'b0001);
         good(1);
      end
      check("sat_cnt", err_cnt, 3);
      check("sat_locked", locked, 1);
      step(1'b0, 1'b1, seq ^ 4'b0010, 1'b1);
      seq = pred(seq);
      check("clr_with_err", err_cnt, 1);
      check("clr_with_err_pulse", err_pulse, 1);

      // Randomised stream with corruption, gaps, clears and rare resets
      step(1'b1, 1'b0, '0, 1'b0);
      seq = 4'b0001;
      for (int i = 0; i < 400; i++) begin
         logic            v;
         logic            clr;
         logic            rst;
         logic [DATA-1:0] d;
         v   = ($urandom_range(0, 99) < 75);
         clr = ($urandom_range(0, 29) == 0);
         rst = ($urandom_range(0, 199) == 0);
         if (v) begin
            d   = ($urandom_range(0, 99) < 10) ? seq ^ 4'($urandom_range(1, 15)) : seq;
            seq = pred(seq);
         end else begin
            d = 4'($urandom);
         end
         step(rst, v, d, clr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
